// File: rtl/my_lsu_pkg.sv
// -----------------------------------------------------------------------------
// my_lsu_pkg
// Shared definitions for the load/store unit: funct3 access-size encodings
// (RISC-V inst[14:12]) and the transaction FSM state type.
// No ports; imported by my_lsu and my_lsu_align.
// -----------------------------------------------------------------------------
package my_lsu_pkg;

   // funct3 access-size encodings. Bits [1:0] give the size, bit 2 marks unsigned loads.
   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   // Size field values, taken from funct3[1:0].
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Bus transaction FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } lsu_state_e;

endpackage : my_lsu_pkg

// File: rtl/my_lsu_align.sv
// -----------------------------------------------------------------------------
// my_lsu_align
// Purely combinational lane logic for the load/store unit.
//   Request side (live datapath inputs):
//     req_store    in   1   access is a store (else a load)
//     req_funct3   in   3   access size / signedness
//     req_addr_lo  in   2   low address bits (byte offset within the word)
//     req_wdata    in  32   store data from rs2
//     req_legal    out  1   funct3 legal for this access kind and address aligned
//     st_be        out  4   store byte enables
//     st_wdata     out 32   store data replicated onto every lane
//   Response side (values latched when the access started):
//     ld_funct3    in   3   latched access size / signedness
//     ld_addr_lo   in   2   latched byte offset
//     bus_rdata    in  32   raw word from the bus
//     ld_data      out 32   selected lane, sign- or zero-extended
// -----------------------------------------------------------------------------
module my_lsu_align
   import my_lsu_pkg::*;
(
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic        req_legal,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] bus_rdata,
   output logic [31:0] ld_data
);

   logic        size_ok;
   logic        align_ok;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Legality: the funct3 encoding must exist for this access kind, and the
   // address must be naturally aligned for the access size.
   // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      size_ok  = 1'b0;
      align_ok = 1'b0;
      case (req_funct3)
         LSU_B, LSU_H, LSU_W: size_ok = 1'b1;
         LSU_BU, LSU_HU:      size_ok = !req_store;
         default:             size_ok = 1'b0;
      endcase
      case (req_funct3[1:0])
         SZ_BYTE: align_ok = 1'b1;
         SZ_HALF: align_ok = !req_addr_lo[0];
         SZ_WORD: align_ok = (req_addr_lo == 2'b00);
         default: align_ok = 1'b0;
      endcase
      req_legal = size_ok && align_ok;
   end

   // Store lanes: data is replicated so the memory only needs the byte enables.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = req_wdata;
      case (req_funct3[1:0])
         SZ_BYTE: begin
            st_be    = 4'b0001 << req_addr_lo;
            st_wdata = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            st_be    = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = req_wdata;
         end
      endcase
   end

   // Load lanes: pick the addressed byte/halfword, then extend per funct3.
   always_comb begin
      case (ld_addr_lo)
         2'd0:    ld_byte = bus_rdata[7:0];
         2'd1:    ld_byte = bus_rdata[15:8];
         2'd2:    ld_byte = bus_rdata[23:16];
         default: ld_byte = bus_rdata[31:24];
      endcase
      ld_half = ld_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

      case (ld_funct3)
         LSU_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         LSU_BU:  ld_data = {24'h0, ld_byte};
         LSU_H:   ld_data = {{16{ld_half[15]}}, ld_half};
         LSU_HU:  ld_data = {16'h0, ld_half};
         default: ld_data = bus_rdata;
      endcase
   end

endmodule : my_lsu_align

// File: rtl/my_lsu.sv
// -----------------------------------------------------------------------------
// my_lsu
// Load/store unit between the single-cycle datapath and a req/ack data bus.
// Starts a bus transaction for each legal load/store, holds `stall` until it
// completes, and returns extended load data.
//   clk, rst          clock; synchronous active-high reset
//   mem_read/write    datapath access request (both high = store)
//   funct3, addr      access size/signedness and effective address
//   wdata             store data (rs2)
//   rdata_out         extended load data (valid in DONE, held otherwise)
//   stall             freeze PC / writeback while the access is in flight
//   misaligned        same-cycle flag for an illegal or misaligned access
//   bus_err           one-cycle flag when the bus timed out
//   bus_req/we/addr/be/wdata   registered bus request
//   bus_ack, bus_rdata         bus response
// -----------------------------------------------------------------------------
module my_lsu
   import my_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata_out,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       addr_lo_q, addr_lo_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             bus_err_q, bus_err_d;
   logic             bus_req_q, bus_req_d;
   logic             bus_we_q, bus_we_d;
   logic [31:0]      bus_addr_q, bus_addr_d;
   logic [3:0]       bus_be_q, bus_be_d;
   logic [31:0]      bus_wdata_q, bus_wdata_d;

   logic        access;
   logic        is_store;
   logic        req_legal;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   assign access   = mem_read || mem_write;
   assign is_store = mem_write;   // a simultaneous read+write is a store

   my_lsu_align u_align (
      .req_store   (is_store),
      .req_funct3  (funct3),
      .req_addr_lo (addr[1:0]),
      .req_wdata   (wdata),
      .req_legal   (req_legal),
      .st_be       (st_be),
      .st_wdata    (st_wdata),
      .ld_funct3   (funct3_q),
      .ld_addr_lo  (addr_lo_q),
      .bus_rdata   (bus_rdata),
      .ld_data     (ld_data)
   );

   // stall and misaligned must react in the same cycle the instruction is
   // presented, so they are decoded from the inputs while in IDLE.
   assign stall      = ((state_q == ST_IDLE) && access && req_legal) || (state_q == ST_REQ);
   assign misaligned = (state_q == ST_IDLE) && access && !req_legal;
   assign rdata_out  = misaligned ? 32'h0 : rdata_q;
   assign bus_err    = bus_err_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      rdata_d     = rdata_q;
      bus_err_d   = 1'b0;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (access && req_legal) begin
               state_d     = ST_REQ;
               cnt_d       = '0;
               funct3_d    = funct3;
               addr_lo_d   = addr[1:0];
               bus_req_d   = 1'b1;
               bus_we_d    = is_store;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_be_d    = is_store ? st_be : 4'b1111;
               bus_wdata_d = is_store ? st_wdata : 32'h0;
            end
         end
         ST_REQ: begin
            if (bus_ack) begin
               state_d   = ST_DONE;
               bus_req_d = 1'b0;
               if (!bus_we_q) begin
                  rdata_d = ld_data;
               end
            end else if (cnt_q == CNT_LAST) begin
               // Abort: the datapath sees zero data and a one-cycle error in DONE.
               state_d   = ST_DONE;
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               rdata_d   = 32'h0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            // The datapath commits at the end of this cycle; never chain a new access.
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
         rdata_q     <= '0;
         bus_err_q   <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         rdata_q     <= rdata_d;
         bus_err_q   <= bus_err_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

endmodule : my_lsu

// File: tb/tb_my_lsu.sv
// -----------------------------------------------------------------------------
// tb_my_lsu
// Self-checking bench for my_lsu (TIMEOUT_CYCLES = 4). Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_my_lsu;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata_out;
   logic        stall;
   logic        misaligned;
   logic        bus_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   my_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .rdata_out  (rdata_out),
      .stall      (stall),
      .misaligned (misaligned),
      .bus_err    (bus_err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;       // word returned by the bus with ack
      int          ack_dly;     // REQ cycles before the ack cycle
      logic        exp_mis;
      logic [31:0] exp_baddr;
      logic [3:0]  exp_be;
      logic        exp_we;
      logic        chk_wdata;
      logic [31:0] exp_bwdata;
      logic [31:0] exp_rdata;   // rdata_out seen in DONE (or held value)
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rdw,
                               input int dly, input logic mis,
                               input logic [31:0] baddr, input logic [3:0] be,
                               input logic we, input logic chk_wd,
                               input logic [31:0] bwd, input logic [31:0] rdo);
      vec_t v;
      v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.rdata = rdw; v.ack_dly = dly; v.exp_mis = mis; v.exp_baddr = baddr;
      v.exp_be = be; v.exp_we = we; v.chk_wdata = chk_wd; v.exp_bwdata = bwd;
      v.exp_rdata = rdo;
      return v;
   endfunction

   task automatic drive_idle();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      funct3    = 3'b000;
      addr      = 32'h0;
      wdata     = 32'h0;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
   endtask

   // One complete access from the IDLE cycle through DONE and back to IDLE.
   task automatic do_access(input vec_t v);
      @(posedge clk); #1;
      mem_read  = v.rd;
      mem_write = v.wr;
      funct3    = v.f3;
      addr      = v.addr;
      wdata     = v.wdata;
      bus_ack   = 1'b0;
      @(negedge clk);
      if (v.exp_mis) begin
         check({v.name, " misaligned"}, misaligned, 1'b1);
         check({v.name, " stall"}, stall, 1'b0);
         check({v.name, " bus_req"}, bus_req, 1'b0);
         check({v.name, " rdata_out"}, rdata_out, 32'h0);
         @(posedge clk); #1;
         drive_idle();
         @(negedge clk);
         check({v.name, " misaligned drop"}, misaligned, 1'b0);
         check({v.name, " no bus_req"}, bus_req, 1'b0);
         return;
      end
      check({v.name, " idle stall"}, stall, 1'b1);
      check({v.name, " idle misaligned"}, misaligned, 1'b0);
      for (int k = 0; k <= v.ack_dly; k++) begin
         @(posedge clk); #1;
         bus_ack   = (k == v.ack_dly);
         bus_rdata = (k == v.ack_dly) ? v.rdata : 32'hA5A5_5A5A;
         @(negedge clk);
         check({v.name, " req bus_req"}, bus_req, 1'b1);
         check({v.name, " req stall"}, stall, 1'b1);
         check({v.name, " bus_addr"}, bus_addr, v.exp_baddr);
         check({v.name, " bus_be"}, bus_be, v.exp_be);
         check({v.name, " bus_we"}, bus_we, v.exp_we);
         if (v.chk_wdata) check({v.name, " bus_wdata"}, bus_wdata, v.exp_bwdata);
      end
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      @(negedge clk);
      check({v.name, " done stall"}, stall, 1'b0);
      check({v.name, " done bus_req"}, bus_req, 1'b0);
      check({v.name, " done bus_err"}, bus_err, 1'b0);
      check({v.name, " rdata_out"}, rdata_out, v.exp_rdata);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check({v.name, " back idle stall"}, stall, 1'b0);
      check({v.name, " rdata_out held"}, rdata_out, v.exp_rdata);
   endtask

   initial begin
      drive_idle();
      rst = 1'b1;

      //           name   rd wr f3      addr          wdata         bus_rdata     dly mis baddr         be       we chk bus_wdata     rdata_out
      vq.push_back(mk("SW",   0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 0, 32'h0000_0100, 4'b1111, 1, 1, 32'hDEAD_BEEF, 32'h0));
      vq.push_back(mk("LB",   1, 0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0200, 4'b1111, 0, 0, 32'h0,        32'hFFFF_FF80));
      vq.push_back(mk("LBU",  1, 0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0200, 4'b1111, 0, 0, 32'h0,        32'h0000_0080));
      vq.push_back(mk("SH",   0, 1, 3'b001, 32'h0000_0402, 32'h0000_ABCD, 32'h0,        0, 0, 32'h0000_0400, 4'b1100, 1, 1, 32'hABCD_ABCD, 32'h0000_0080));
      vq.push_back(mk("LH",   1, 0, 3'b001, 32'h0000_0402, 32'h0,        32'h8001_0000, 2, 0, 32'h0000_0400, 4'b1111, 0, 0, 32'h0,        32'hFFFF_8001));
      vq.push_back(mk("SB",   0, 1, 3'b000, 32'h0000_0101, 32'h1234_567E, 32'h0,        0, 0, 32'h0000_0100, 4'b0010, 1, 1, 32'h7E7E_7E7E, 32'hFFFF_8001));
      vq.push_back(mk("LHU",  1, 0, 3'b101, 32'h0000_0000, 32'h0,        32'h1234_F00D, 1, 0, 32'h0000_0000, 4'b1111, 0, 0, 32'h0,        32'h0000_F00D));
      vq.push_back(mk("LW",   1, 0, 3'b010, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 0, 0, 32'h0000_0008, 4'b1111, 0, 0, 32'h0,        32'hCAFE_F00D));
      vq.push_back(mk("LWmis",1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 0, 0, 32'h0,        32'h0));
      vq.push_back(mk("SHmis",0, 1, 3'b001, 32'h0000_0103, 32'h0000_1111, 32'h0,        0, 1, 32'h0,        4'b0000, 0, 0, 32'h0,        32'h0));
      vq.push_back(mk("Lf011",1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 0, 0, 32'h0,        32'h0));
      vq.push_back(mk("Sf100",0, 1, 3'b100, 32'h0000_0000, 32'h0000_00AA, 32'h0,        0, 1, 32'h0,        4'b0000, 0, 0, 32'h0,        32'h0));
      vq.push_back(mk("RWst", 1, 1, 3'b010, 32'h0000_0020, 32'h1122_3344, 32'h0,        0, 0, 32'h0000_0020, 4'b1111, 1, 1, 32'h1122_3344, 32'hCAFE_F00D));
      vq.push_back(mk("LBpos",1, 0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 0, 32'h0000_0000, 4'b1111, 0, 0, 32'h0,        32'h0000_007F));
      vq.push_back(mk("LHneg",1, 0, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_8000, 0, 0, 32'h0000_0000, 4'b1111, 0, 0, 32'h0,        32'hFFFF_8000));

      // Reset state.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset stall", stall, 1'b0);
      check("reset bus_req", bus_req, 1'b0);
      check("reset bus_err", bus_err, 1'b0);
      check("reset misaligned", misaligned, 1'b0);
      check("reset rdata_out", rdata_out, 32'h0);
      check("reset bus_addr", bus_addr, 32'h0);
      check("reset bus_be", bus_be, 4'h0);

      foreach (vq[i]) do_access(vq[i]);

      // Reset in REQ with a same-cycle ack: the ack is discarded.
      @(posedge clk); #1;
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0080;
      @(negedge clk);
      check("rstreq idle stall", stall, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1234_5678; mem_read = 1'b0;
      @(negedge clk);
      check("rstreq req bus_req", bus_req, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
      @(negedge clk);
      check("rstreq bus_req", bus_req, 1'b0);
      check("rstreq stall", stall, 1'b0);
      check("rstreq bus_err", bus_err, 1'b0);
      check("rstreq rdata_out", rdata_out, 32'h0);
      check("rstreq bus_addr", bus_addr, 32'h0);
      check("rstreq bus_be", bus_be, 4'h0);
      check("rstreq bus_we", bus_we, 1'b0);
      do_access(mk("LWpost", 1, 0, 3'b010, 32'h0000_0084, 32'h0, 32'h0BAD_C0DE, 0, 0,
                   32'h0000_0084, 4'b1111, 0, 0, 32'h0, 32'h0BAD_C0DE));

      // Timeout: four REQ cycles with no ack, then bus_err in DONE.
      @(posedge clk); #1;
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040;
      @(negedge clk);
      check("tmo idle stall", stall, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         bus_ack = 1'b0;
         @(negedge clk);
         check("tmo req bus_req", bus_req, 1'b1);
         check("tmo req stall", stall, 1'b1);
         check("tmo req bus_err", bus_err, 1'b0);
      end
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;   // ack in DONE is ignored
      @(negedge clk);
      check("tmo done bus_err", bus_err, 1'b1);
      check("tmo done rdata_out", rdata_out, 32'h0);
      check("tmo done stall", stall, 1'b0);
      check("tmo done bus_req", bus_req, 1'b0);
      @(posedge clk); #1;
      mem_read = 1'b0;                              // ack still high in IDLE
      @(negedge clk);
      check("tmo bus_err pulse", bus_err, 1'b0);
      check("tmo rdata held", rdata_out, 32'h0);
      check("idle ack bus_req", bus_req, 1'b0);
      check("idle ack stall", stall, 1'b0);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check("idle ack no start", bus_req, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_my_lsu
